// File: rtl/oc_rotate_ctrl_pkg.sv
// oc_rotate_ctrl_pkg: bank geometry and FSM states shared by the rotate controller
package oc_rotate_ctrl_pkg;
  localparam int NUM_WARP_LOG = 3;
  localparam int SIZE_REGFILE_BR = 4;
  localparam int REGFILE_BR_INDEX = NUM_WARP_LOG + SIZE_REGFILE_BR;
  localparam int SIZE_DATA = 32;
  localparam logic [SIZE_REGFILE_BR-1:0] LAST_REG = '1;
  typedef enum logic [2:0] {
    ROT_IDLE,
    ROT_DRAIN,
    ROT_SAVE,
    ROT_RESTORE,
    ROT_FINISH
  } rot_state_e;
endpackage

// File: rtl/oc_rotate_ctrl.sv
// oc_rotate_ctrl: saves/restores one warp's registers through the OC bank rotate port
module oc_rotate_ctrl
  import oc_rotate_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmdValid_i,
  output logic                        cmdReady_o,
  input  logic                        cmdSave_i,
  input  logic [NUM_WARP_LOG-1:0]     cmdWarp_i,
  input  logic                        pipeIdle_i,
  output logic                        stallPipe_o,
  output logic                        rotate_o,
  output logic                        rotateValid_o,
  output logic                        rotateWE_o,
  output logic [REGFILE_BR_INDEX-1:0] rotateRegAddr_o,
  output logic [SIZE_DATA-1:0]        rotateDin_o,
  input  logic [SIZE_DATA-1:0]        rotateDout_i,
  output logic                        saveValid_o,
  input  logic                        saveReady_i,
  output logic [SIZE_DATA-1:0]        saveData_o,
  input  logic                        rstrValid_i,
  output logic                        rstrReady_o,
  input  logic [SIZE_DATA-1:0]        rstrData_i,
  output logic                        done_o
);
  rot_state_e state_q, state_d;
  logic save_q;
  logic [NUM_WARP_LOG-1:0] warp_q;
  logic [SIZE_REGFILE_BR-1:0] idx_q;
  logic rd_done_q, sv_valid_q;
  logic [SIZE_DATA-1:0] sv_data_q;
  logic cmd_fire, rd_fire, wr_fire, last, rot;
  assign cmd_fire = cmdValid_i && state_q == ROT_IDLE;
  // a read may only fire when the skid register is free or drains this cycle
  assign rd_fire = state_q == ROT_SAVE && !rd_done_q && (!sv_valid_q || saveReady_i);
  assign wr_fire = state_q == ROT_RESTORE && rstrValid_i;
  assign last = idx_q == LAST_REG;
  assign rot = state_q == ROT_SAVE || state_q == ROT_RESTORE;
  always_ff @(posedge clk) begin
    if (reset) state_q <= ROT_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ROT_IDLE:    if (cmdValid_i) state_d = ROT_DRAIN;
      ROT_DRAIN:   if (pipeIdle_i) state_d = save_q ? ROT_SAVE : ROT_RESTORE;
      ROT_SAVE:    if (rd_done_q && sv_valid_q && saveReady_i) state_d = ROT_FINISH;
      ROT_RESTORE: if (wr_fire && last) state_d = ROT_FINISH;
      ROT_FINISH:  state_d = ROT_IDLE;
      default:     state_d = ROT_IDLE;
    endcase
  end
  always_comb begin
    cmdReady_o = state_q == ROT_IDLE;
    stallPipe_o = state_q != ROT_IDLE;
    rotate_o = rot;
    rotateValid_o = rd_fire || wr_fire;
    rotateWE_o = wr_fire;
    rotateRegAddr_o = rot ? {warp_q, idx_q} : '0;
    rotateDin_o = wr_fire ? rstrData_i : '0;
    rstrReady_o = state_q == ROT_RESTORE;
    done_o = state_q == ROT_FINISH;
  end
  assign saveValid_o = sv_valid_q;
  assign saveData_o = sv_data_q;
  // the index saturates on the last register so the address stays inside the warp
  always_ff @(posedge clk) begin
    if (reset) begin
      save_q <= 1'b0;
      warp_q <= '0;
      idx_q <= '0;
      rd_done_q <= 1'b0;
      sv_valid_q <= 1'b0;
      sv_data_q <= '0;
    end else begin
      if (cmd_fire) begin
        save_q <= cmdSave_i;
        warp_q <= cmdWarp_i;
        idx_q <= '0;
        rd_done_q <= 1'b0;
      end
      if (rd_fire || wr_fire) idx_q <= last ? idx_q : idx_q + 1'b1;
      if (rd_fire && last) rd_done_q <= 1'b1;
      if (rd_fire) sv_data_q <= rotateDout_i;
      sv_valid_q <= rd_fire || (sv_valid_q && !saveReady_i);
    end
  end
endmodule

// File: tb/tb_oc_rotate_ctrl.sv
// tb_oc_rotate_ctrl: transaction-level model of save/restore checked against the DUT every cycle
module tb_oc_rotate_ctrl;
  import oc_rotate_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmdValid_i, cmdReady_o, cmdSave_i, pipeIdle_i, stallPipe_o;
  logic [NUM_WARP_LOG-1:0] cmdWarp_i;
  logic rotate_o, rotateValid_o, rotateWE_o;
  logic [REGFILE_BR_INDEX-1:0] rotateRegAddr_o;
  logic [SIZE_DATA-1:0] rotateDin_o, rotateDout_i, saveData_o, rstrData_i;
  logic saveValid_o, saveReady_i, rstrValid_i, rstrReady_o, done_o;
  logic [SIZE_DATA-1:0] mem [0:(1<<REGFILE_BR_INDEX)-1];
  int n_chk = 0, n_err = 0, cyc = 0, wr_cnt = 0;
  logic [31:0] exp_q [$];
  int save_words = 0, done_cnt = 0, done_cyc = 0, first_cyc = 0, last_cyc = 0, rn = 16;
  logic [31:0] first_word, last_word, hold_data, w;
  logic [2:0] rwarp;
  logic done_due = 1'b0, hold = 1'b0, idle_seen = 1'b0;

  oc_rotate_ctrl dut (
    .clk(clk), .reset(reset), .cmdValid_i(cmdValid_i), .cmdReady_o(cmdReady_o),
    .cmdSave_i(cmdSave_i), .cmdWarp_i(cmdWarp_i), .pipeIdle_i(pipeIdle_i),
    .stallPipe_o(stallPipe_o), .rotate_o(rotate_o), .rotateValid_o(rotateValid_o),
    .rotateWE_o(rotateWE_o), .rotateRegAddr_o(rotateRegAddr_o), .rotateDin_o(rotateDin_o),
    .rotateDout_i(rotateDout_i), .saveValid_o(saveValid_o), .saveReady_i(saveReady_i),
    .saveData_o(saveData_o), .rstrValid_i(rstrValid_i), .rstrReady_o(rstrReady_o),
    .rstrData_i(rstrData_i), .done_o(done_o)
  );

  always #5 clk = ~clk;
  assign rotateDout_i = mem[rotateRegAddr_o];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && rotateValid_o && rotateWE_o) begin
      mem[rotateRegAddr_o] <= rotateDin_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // model: a save must stream the warp's 16 words in order, a restore must write 16 words in order
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold = 1'b0;
      done_due = 1'b0;
      idle_seen = 1'b0;
      rn = 16;
    end else begin
      chk("done", {31'd0, done_o}, {31'd0, done_due});
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      done_due = 1'b0;
      chk("ready_vs_stall", {31'd0, cmdReady_o}, {31'd0, !stallPipe_o});
      if (rotate_o) chk("rotate_gate", {31'd0, idle_seen}, 32'd1);
      idle_seen = stallPipe_o && (idle_seen || pipeIdle_i);
      if (hold) begin
        chk("hold_valid", {31'd0, saveValid_o}, 32'd1);
        chk("hold_data", saveData_o, hold_data);
      end
      hold = saveValid_o && !saveReady_i;
      hold_data = saveData_o;
      if (exp_q.size() == 0) chk("no_extra_word", {31'd0, saveValid_o}, 32'd0);
      else if (saveValid_o && saveReady_i) begin
        w = exp_q.pop_front();
        chk("save_word", saveData_o, w);
        if (save_words == 0) begin
          first_word = saveData_o;
          first_cyc = cyc;
        end
        save_words++;
        last_word = saveData_o;
        last_cyc = cyc;
        if (exp_q.size() == 0) done_due = 1'b1;
      end
      if (rstrReady_o && rstrValid_i) begin
        chk("wr_strobe", {30'd0, rotateValid_o, rotateWE_o}, 32'd3);
        chk("wr_addr", {25'd0, rotateRegAddr_o}, {25'd0, rwarp, rn[3:0]});
        chk("wr_data", rotateDin_o, rstrData_i);
        rn++;
        if (rn == 16) done_due = 1'b1;
      end else if (rstrReady_o) chk("wr_idle", {31'd0, rotateValid_o}, 32'd0);
      if (cmdValid_i && cmdReady_o) begin
        save_words = 0;
        exp_q.delete();
        if (cmdSave_i) for (int r = 0; r < 16; r++) exp_q.push_back(mem[{cmdWarp_i, r[3:0]}]);
        else begin
          rwarp = cmdWarp_i;
          rn = 0;
        end
      end
    end
  end

  task automatic issue(input logic s, input logic [2:0] wp);
    @(posedge clk); #1;
    chk("cmd_ready", {31'd0, cmdReady_o}, 32'd1);
    cmdValid_i = 1'b1;
    cmdSave_i = s;
    cmdWarp_i = wp;
    @(posedge clk); #1;
    cmdValid_i = 1'b0;
    chk("stall_after_accept", {31'd0, stallPipe_o}, 32'd1);
  endtask

  task automatic wait_done(input int d0, input int lim);
    int i = 0;
    while (done_cnt == d0 && i < lim) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk("done_seen", done_cnt, d0 + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int d0, wc0, k;
    logic acc;
    cmdValid_i = 0; cmdSave_i = 0; cmdWarp_i = 0; pipeIdle_i = 1; saveReady_i = 1;
    rstrValid_i = 0; rstrData_i = 0;
    for (int a = 0; a < 128; a++) mem[a] <= 32'h5A00_0000 + a;
    for (int r = 0; r < 16; r++) mem[{3'd3, r[3:0]}] <= 32'h100 + r;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_cmdReady", {31'd0, cmdReady_o}, 32'd1);
    chk("rst_stall", {31'd0, stallPipe_o}, 32'd0);
    chk("rst_rotate", {31'd0, rotate_o}, 32'd0);
    chk("rst_saveValid", {31'd0, saveValid_o}, 32'd0);
    chk("rst_saveData", saveData_o, 32'd0);
    chk("rst_rstrReady", {31'd0, rstrReady_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_addr", {25'd0, rotateRegAddr_o}, 32'd0);
    // save warp 3, no backpressure
    d0 = done_cnt;
    issue(1'b1, 3'd3);
    wait_done(d0, 100);
    chk("s1_count", save_words, 16);
    chk("s1_first", first_word, 32'h100);
    chk("s1_last", last_word, 32'h10F);
    chk("s1_consecutive", last_cyc - first_cyc, 15);
    chk("s1_done_latency", done_cyc - last_cyc, 1);
    // save warp 2 with toggling ready and a command pulse while busy
    d0 = done_cnt;
    wc0 = wr_cnt;
    issue(1'b1, 3'd2);
    for (int i = 0; i < 120 && done_cnt == d0; i++) begin
      saveReady_i = (i % 2) == 0;
      cmdValid_i = i == 6;
      cmdSave_i = 1'b0;
      cmdWarp_i = 3'd7;
      if (i == 6) chk("busy_cmdReady", {31'd0, cmdReady_o}, 32'd0);
      @(posedge clk); #1;
    end
    cmdValid_i = 1'b0;
    saveReady_i = 1'b1;
    chk("s2_done_seen", done_cnt, d0 + 1);
    chk("s2_count", save_words, 16);
    chk("s2_first", first_word, 32'h5A00_0020);
    chk("s2_last", last_word, 32'h5A00_002F);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_not_queued", {31'd0, stallPipe_o}, 32'd0);
    chk("busy_no_writes", wr_cnt - wc0, 0);
    // restore warp 5 with random valid gaps
    d0 = done_cnt;
    wc0 = wr_cnt;
    k = 0;
    issue(1'b0, 3'd5);
    for (int i = 0; i < 300 && k < 16; i++) begin
      rstrValid_i = $urandom_range(0, 2) != 0;
      rstrData_i = 32'hA0 + k;
      @(negedge clk);
      acc = rstrValid_i && rstrReady_o;
      @(posedge clk); #1;
      if (acc) k++;
    end
    rstrValid_i = 1'b0;
    wait_done(d0, 10);
    chk("r_write_count", wr_cnt - wc0, 16);
    chk("r_mem50", mem[7'h50], 32'hA0);
    chk("r_mem5F", mem[7'h5F], 32'hAF);
    for (int r = 0; r < 16; r++) begin
      chk("r_warp5", mem[{3'd5, r[3:0]}], 32'hA0 + r);
      chk("r_warp4", mem[{3'd4, r[3:0]}], 32'h5A00_0040 + r);
      chk("r_warp6", mem[{3'd6, r[3:0]}], 32'h5A00_0060 + r);
    end
    // drain wait on warp 1
    d0 = done_cnt;
    pipeIdle_i = 1'b0;
    issue(1'b1, 3'd1);
    for (int i = 0; i < 10; i++) begin
      chk("drain_stall", {31'd0, stallPipe_o}, 32'd1);
      chk("drain_rotate", {30'd0, rotate_o, rotateValid_o}, 32'd0);
      @(posedge clk); #1;
    end
    pipeIdle_i = 1'b1;
    @(posedge clk); #1;
    chk("drain_first_access", {30'd0, rotate_o, rotateValid_o}, 32'd3);
    chk("drain_first_addr", {25'd0, rotateRegAddr_o}, 32'h10);
    wait_done(d0, 100);
    chk("d_count", save_words, 16);
    chk("d_first", first_word, 32'h5A00_0010);
    // reset abort after the 7th save word
    d0 = done_cnt;
    issue(1'b1, 3'd3);
    for (int i = 0; i < 100 && save_words < 7; i++) @(posedge clk);
    chk("abort_words", save_words, 7);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_cmdReady", {31'd0, cmdReady_o}, 32'd1);
    chk("abort_saveValid", {31'd0, saveValid_o}, 32'd0);
    chk("abort_rotate", {31'd0, rotate_o}, 32'd0);
    chk("abort_stall", {31'd0, stallPipe_o}, 32'd0);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_mem_kept", mem[7'h5F], 32'hAF);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
